uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle line high. It oversamples the line with a per-bit clock counter and samples each bit at its centre. It delivers each received byte on a valid/ack handshake and flags framing errors and overruns. It is the receive side of the team's UART link and sits between the external RXD pin and the byte consumer.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535; HALF = CLKS_PER_BIT/2, floor division.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  received byte; valid only while `valid`=1.
- valid  output  1  a byte is held in `data`, awaiting `ack`.
- ack  input  1  consumer accepts the byte; sampled only when `valid`=1.
- busy  output  1  high while a frame is being received (any state except IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: a good frame completed while `valid`=1 and `ack`=0.

## Operation
- A two-flop synchronizer brings `rxd` into the clk domain; both flops reset to 1. All logic below uses the synchronized value `rxs`.
- Reset values: data=0x00, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counters=0.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rxs`=0, go to START and clear the cycle counter.
- START: count HALF cycles, then sample. If `rxs`=1 it is a false start: return to IDLE with no output activity. If `rxs`=0, go to DATA with bit index 0.
- DATA: sample every CLKS_PER_BIT cycles and shift into the shift register LSB first. After bit index 7, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - `rxs`=1: complete the frame and go to IDLE.
  - `rxs`=0: pulse `frame_err`, discard the byte and go to BREAK.
- BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from being seen as repeated starts.
- Frame completion:
  - If `valid`=0, or `valid`=1 with `ack`=1 in the same cycle: load `data` and set `valid`=1.
  - Otherwise: pulse `overrun`, drop the new byte, and keep `data` and `valid` unchanged.
- Handshake: `valid`=1 with `ack`=1 clears `valid` on the next edge, unless a completion in the same cycle reloads it. `data` holds its value after the handshake.
- While `valid`=0, `ack` has no effect.
- The counters are wide enough for CLKS_PER_BIT-1. The bit index is 3 bits.

## Timing
- The `rxd` falling edge at pin cycle p is seen as `rxs`=0 at t0 = p+2; IDLE leaves at t0.
- Start sample: t0+HALF.
- Data bit i sample: t0+HALF+(i+1)*CPB, for i=0..7.
- Stop sample: t0+HALF+9*CPB.
- `valid`, `frame_err` and `overrun` all assert at t0+HALF+9*CPB+1. For CPB=16 this is t0+153.
- `busy` is high from t0+1 until the cycle after the return to IDLE.
- A new start is accepted in the first IDLE cycle. Back-to-back frames with zero idle time between stop and start are received correctly.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Bits already received are lost. After reset, reception restarts on the next falling edge.

## Test plan
- CPB=16, send 0xA5 with a correct stop bit -> `valid` rises 155 cycles after the pin edge, `data`=0xA5. After `ack`, `valid`=0 the next cycle.
- 3-cycle low glitch on an idle `rxd` -> START returns to IDLE; `valid`, `frame_err` and `busy` end low; no byte delivered.
- Send 0x3C with the stop bit forced 0 and the line held low for 40 bit times -> one `frame_err` pulse, `valid` stays 0, no further frames. When the line goes high, the next frame 0x81 is received correctly.
- Send 0x11 then 0x22 back-to-back with `ack` held 0 -> `data`=0x11 is retained and `overrun` pulses once at the second completion. Then `ack` -> `valid` drops.
- Send 0x55 then 0xAA back-to-back, with `ack` asserted in exactly the cycle 0xAA completes -> `data`=0xAA, `valid` stays 1, no `overrun`.
- Assert `rst` low at bit 4 of a 0xF0 frame -> all outputs are at reset values immediately. A following 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronised line, centre sampling from a
// per-bit cycle counter, valid/ack byte handoff with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_sync1;
    logic          r_sync2;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic w_rxs;
    logic w_half_done;
    logic w_bit_done;
    logic w_stop_sample;
    logic w_complete;
    logic w_accept;

    assign w_rxs         = r_sync2;
    assign w_half_done   = (r_cnt == HALF_END);
    assign w_bit_done    = (r_cnt == BIT_END);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_done;
    assign w_complete    = w_stop_sample && w_rxs;
    // A completion may reuse the holding register in the same cycle it is acknowledged.
    assign w_accept      = !r_valid || ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= w_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && !w_rxs;
            r_overrun   <= w_complete && !w_accept;
            if (w_complete && w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a line-level reference of the 8N1 receiver:
// each frame's delivery/error outcome and its fixed pin-to-output latency.
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned FRAME = 10 * CPB;
    // Pin edge to output: 2 sync flops, half bit, nine full bits, one register stage.
    localparam int unsigned LAT   = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned fe_seen = 0;
    int unsigned ov_seen = 0;
    int unsigned exp_fe = 0;
    logic [7:0]  exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
        .ack(ack), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen <= fe_seen + 1;
        if (overrun === 1'b1) ov_seen <= ov_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Line waveform of one frame: start 0, data LSB first, stop bit.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int unsigned cycles);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int unsigned c = 0; c < cycles; c++) begin
            rxd = f[c / CPB];
            tick(1);
        end
    endtask

    task automatic recv_frame(input logic [7:0] d);
        logic [7:0] e;
        exp_q.push_back(d);
        fork
            drive_frame(d, 1'b1, FRAME);
            begin
                tick(LAT / 2);
                check("busy_mid", busy, 1);
                tick(LAT - 1 - LAT / 2);
                check("valid_early", valid, 0);
                tick(1);
                check("valid_on_time", valid, 1);
                e = exp_q.pop_front();
                check("data", data, e);
            end
        join
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("valid_after_ack", valid, 0);
        check("data_hold", data, e);
    endtask

    task automatic bad_frame(input logic [7:0] d);
        exp_fe++;
        fork
            drive_frame(d, 1'b0, FRAME);
            begin
                tick(LAT - 1);
                check("ferr_early", frame_err, 0);
                tick(1);
                check("ferr_pulse", frame_err, 1);
                check("ferr_no_valid", valid, 0);
                tick(1);
                check("ferr_one_cycle", frame_err, 0);
            end
        join
        rxd = 1'b1;
    endtask

    initial begin
        int unsigned fe_base;
        int unsigned ov_base;
        logic [7:0] d;
        rxd = 1'b1;
        ack = 1'b0;
        rst = 1'b0;
        tick(3);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b1;
        tick(5);

        recv_frame(8'hA5);

        fe_base = fe_seen;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(1);
        check("glitch_busy", busy, 1);
        tick(20);
        check("glitch_idle", busy, 0);
        check("glitch_valid", valid, 0);
        check("glitch_ferr", fe_seen - fe_base, 0);

        fe_base = fe_seen;
        exp_fe = 0;
        bad_frame(8'h3C);
        rxd = 1'b0;
        tick(40 * CPB);
        check("break_busy", busy, 1);
        check("break_valid", valid, 0);
        check("break_one_ferr", fe_seen - fe_base, exp_fe);
        rxd = 1'b1;
        tick(4);
        check("break_exit", busy, 0);
        tick(10);
        recv_frame(8'h81);

        ov_base = ov_seen;
        drive_frame(8'h11, 1'b1, FRAME);
        drive_frame(8'h22, 1'b1, FRAME);
        tick(4);
        check("ovr_valid", valid, 1);
        check("ovr_data_kept", data, 8'h11);
        check("ovr_one_pulse", ov_seen - ov_base, 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ovr_ack", valid, 0);

        ov_base = ov_seen;
        fork
            begin
                drive_frame(8'h55, 1'b1, FRAME);
                drive_frame(8'hAA, 1'b1, FRAME);
            end
            begin
                tick(LAT);
                check("b2b_first", data, 8'h55);
                tick(FRAME + LAT - 1 - LAT);
                ack = 1'b1;
                tick(1);
                ack = 1'b0;
                check("b2b_reload_valid", valid, 1);
                check("b2b_reload_data", data, 8'hAA);
                check("b2b_no_ovr_pulse", overrun, 0);
            end
        join
        check("b2b_no_ovr", ov_seen - ov_base, 0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("b2b_ack", valid, 0);

        drive_frame(8'hF0, 1'b1, 5 * CPB + HALF);
        check("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        rxd = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        recv_frame(8'h0F);

        fe_base = fe_seen;
        exp_fe = 0;
        for (int unsigned it = 0; it < 12; it++) begin
            d = 8'($urandom_range(0, 255));
            rxd = 1'b1;
            tick($urandom_range(3, 12));
            if ($urandom_range(0, 3) != 0) recv_frame(d);
            else bad_frame(d);
        end
        rxd = 1'b1;
        tick(4);
        check("rand_ferr_total", fe_seen - fe_base, exp_fe);
        check("rand_final_idle", busy, 0);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
